// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 14;

  // Counter width for WIDTH/BITS_PER_CYCLE steps, never narrower than one bit.
  function automatic int cnt_width(input int width, input int bits_per_cycle);
    int steps;
    steps = width / bits_per_cycle;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor slice: d = x - y - bi, bo set when the slice borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor, diff = a - b - bin, LSB first, BITS_PER_CYCLE bits per clock.
// Define SERIAL_SUB_SAT_EN to clamp the result to zero when the final borrow is set.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic [WIDTH-1:0]          res_next;

  // Borrow ripples through the slices within a cycle and is registered between cycles.
  assign chain[0] = brw_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
    full_subtractor u_fs (
      .x  (a_q[i]),
      .y  (b_q[i]),
      .bi (chain[i]),
      .d  (slice_d[i]),
      .bo (chain[i+1])
    );
  end

  // New result bits enter at the top so the LSB lands at bit 0 after the last step.
  assign res_next = WIDTH'({slice_d, res_q} >> BITS_PER_CYCLE);

  // NOTE: every *_d gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        brw_d = chain[BITS_PER_CYCLE];
        res_d = res_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = chain[BITS_PER_CYCLE];
`ifdef SERIAL_SUB_SAT_EN
          diff_d  = chain[BITS_PER_CYCLE] ? '0 : res_next;
`else
          diff_d  = res_next;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle unsigned subtractor; the counterpart to the team's 14-bit ripple adder.
- Computes diff = a - b - bin, LSB first, BITS_PER_CYCLE bits per clock.
- Start/busy/done handshake.
- Used where the datapath needs the inverse operation with small area, reusing a narrow full-subtractor slice iteratively.

Parameters:
- WIDTH, 14, operand and result width in bits.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH evenly (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- bin  input  1  borrow-in; latched on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; holds the last completed value.
- bout  output  1  borrow-out of the MSB (1 means a < b + bin).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift regs and counter cleared.
- FSM states:
  - IDLE: start=1 at edge k latches a, b and bin into shift regs, clears count, state=RUN, busy=1 after edge k.
  - RUN: each edge processes the BITS_PER_CYCLE LSBs through a chain of full subtractors, shifts the results into a result reg, and carries the borrow in a register. Count increments.
  - Completion: on the edge where count reaches N-1 (N = WIDTH/BITS_PER_CYCLE), diff <= the full result and bout <= the final borrow. done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: the start edge is k; done is high in the cycle after edge k+N. With defaults, N=14.
- Bit slice: d = x^y^bi; bo = (~x&y) | (~x&bi) | (y&bi).
- start while busy=1: ignored. Operands are not re-latched and the result is unaffected.
- start in the done cycle: accepted, since busy=0. Back-to-back throughput is one result per N+1 cycles.
- diff/bout: unchanged during RUN (previous result stays visible); updated only at completion.
- rst mid-RUN: operation aborted, no done pulse, all outputs return to reset values on that edge.
- rst and start in the same cycle: rst wins.
- Inputs a, b and bin may change freely after the accepting edge.

Optional Feature:
- Macro SERIAL_SUB_SAT_EN.
- Defined: unsigned saturation. When the final borrow is 1, diff is forced to 0 at completion; bout still reports 1.
- Undefined: diff is the two's-complement wrap result modulo 2^WIDTH.
- Latency and handshake are identical in both builds.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, RUN), default WIDTH constant (14), and a count-width function clog2(WIDTH/BITS_PER_CYCLE).
- One sub-module, full_subtractor (x, y, bi -> d, bo), instantiated BITS_PER_CYCLE times in a generate chain; the borrow of slice i feeds slice i+1.
- Control FSM and shift registers stay in the top module.

Test Plan:
- a=100, b=58, bin=0, defaults -> done 14 cycles after the start edge; diff=42, bout=0; busy high for exactly 14 cycles.
- a=0, b=1, bin=0 -> diff=0x3FFF, bout=1. With SERIAL_SUB_SAT_EN: diff=0, bout=1.
- a=0x3FFF, b=0x3FFF, bin=1 -> diff=0x3FFF, bout=1. Then a=0x2000, b=0x1FFF, bin=1 -> diff=0, bout=0.
- Start a=500, b=200; pulse start again at cycle 3 with a=1, b=2 -> one done only; diff=300, bout=0.
- Start a=9, b=4, then rst at cycle 5 of RUN -> next edge busy=0, diff=0, no done pulse. A following start a=9, b=4 -> diff=5.
- BITS_PER_CYCLE=2, a=1000, b=1; re-assert start in the done cycle with a=7, b=9 -> first done 7 cycles after start with diff=999. Second done 7 cycles after its accept with diff=0x3FFE, bout=1.
